// File: rtl/ahb_lite_master.sv
// AHB-Lite single-master initiator: turns a valid/ready command stream into
// pipelined SINGLE NONSEQ transfers and returns one response per command.
module ahb_lite_master #(
  parameter int ADDRWIDTH = 12
) (
  input  logic                 hclk,
  input  logic                 hresetn,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_addr,
  input  logic [1:0]           cmd_size,
  input  logic [31:0]          cmd_wdata,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_rdata,
  output logic                 rsp_err,
  output logic [ADDRWIDTH-1:0] haddr,
  output logic [1:0]           htrans,
  output logic                 hwrite,
  output logic [2:0]           hsize,
  output logic [2:0]           hburst,
  output logic [31:0]          hwdata,
  input  logic                 hready,
  input  logic                 hresp,
  input  logic [31:0]          hrdata
);

  // Encoding puts htrans[1] on bit 2 and the replay flag on bit 0, so both
  // bus outputs come straight from state flops.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'b000,
    ST_BUSY   = 3'b100,
    ST_HOLD   = 3'b001,
    ST_REPLAY = 3'b101
  } ap_state_e;

  ap_state_e   state_q, state_d;
  logic        load;
  logic [1:0]  size_c;
  logic [31:0] pend_wdata;
  logic        dp_valid;
  logic        dp_write;

  assign htrans    = {state_q[2], 1'b0};
  assign hburst    = 3'b000;
  assign cmd_ready = hready & ~hresp & ~state_q[0];
  assign size_c    = (cmd_size == 2'b11) ? 2'b10 : cmd_size;

  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    if (hready) begin
      unique case (state_q)
        ST_HOLD:   state_d = ST_REPLAY;
        ST_REPLAY: state_d = ST_IDLE;
        default: begin
          load    = cmd_valid & cmd_ready;
          state_d = load ? ST_BUSY : ST_IDLE;
        end
      endcase
    end else if (hresp && state_q[2]) begin
      // First ERROR cycle: withdraw the pending address phase, keep it for replay.
      state_d = ST_HOLD;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      haddr      <= '0;
      hwrite     <= 1'b0;
      hsize      <= '0;
      hwdata     <= '0;
      pend_wdata <= '0;
      dp_valid   <= 1'b0;
      dp_write   <= 1'b0;
      rsp_valid  <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      if (hready) begin
        if (load) begin
          haddr      <= cmd_addr;
          hwrite     <= cmd_write;
          hsize      <= {1'b0, size_c};
          pend_wdata <= cmd_wdata;
        end
        dp_valid <= state_q[2];
        if (state_q[2]) begin
          dp_write <= hwrite;
          hwdata   <= pend_wdata;
        end
        if (dp_valid) begin
          rsp_valid <= 1'b1;
          rsp_err   <= hresp;
          rsp_rdata <= dp_write ? '0 : hrdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_ahb_lite_master.sv
// Bench for ahb_lite_master: reactive slave model with a transfer scoreboard
// checked every cycle, plus directed scenarios with literal expectations.
module tb_ahb_lite_master;
  localparam int AW = 12;

  logic          hclk;
  logic          hresetn;
  logic          cmd_valid;
  logic          cmd_ready;
  logic          cmd_write;
  logic [AW-1:0] cmd_addr;
  logic [1:0]    cmd_size;
  logic [31:0]   cmd_wdata;
  logic          rsp_valid;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic [AW-1:0] haddr;
  logic [1:0]    htrans;
  logic          hwrite;
  logic [2:0]    hsize;
  logic [2:0]    hburst;
  logic [31:0]   hwdata;
  logic          hready = 1'b1;
  logic          hresp = 1'b0;
  logic [31:0]   hrdata = '0;

  int errors = 0;
  int checks = 0;

  ahb_lite_master #(.ADDRWIDTH(AW)) dut (
    .hclk(hclk), .hresetn(hresetn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_size(cmd_size), .cmd_wdata(cmd_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .haddr(haddr), .htrans(htrans), .hwrite(hwrite), .hsize(hsize),
    .hburst(hburst), .hwdata(hwdata),
    .hready(hready), .hresp(hresp), .hrdata(hrdata)
  );

  initial hclk = 1'b0;
  always #5 hclk = ~hclk;

  task automatic chk_eq(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Slave personality per address
  function automatic int waits_of(input logic [AW-1:0] a);
    if (a == 12'h020) return 2;
    if (a == 12'h040) return 3;
    return 0;
  endfunction

  function automatic logic err_of(input logic [AW-1:0] a);
    return a == 12'h100;
  endfunction

  function automatic logic [31:0] rdata_of(input logic [AW-1:0] a);
    if (a == 12'h020) return 32'h12345678;
    return {20'hC0FFE, a};
  endfunction

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          write;
    logic [2:0]    size;
    logic [31:0]   wdata;
  } xfer_t;

  xfer_t         issue_q[$];
  xfer_t         dp_x;
  xfer_t         x;
  logic          dp_act = 1'b0;
  int            dp_wait;
  logic          dp_err;
  logic          dp_estage;
  logic          cancel_pend = 1'b0;
  logic          exp_rv = 1'b0;
  logic [31:0]   exp_rd;
  logic          exp_re;
  logic [31:0]   last_rd = '0;
  logic          last_re = 1'b0;
  logic          prev_ok = 1'b0;
  logic          prev_hready, prev_hresp, prev_hwrite;
  logic [1:0]    prev_htrans;
  logic [AW-1:0] prev_haddr;
  logic [2:0]    prev_hsize;
  logic [1:0]    exp_ht;
  int            cyc = 0;

  // Slave + scoreboard: drive slave inputs on the falling edge, then predict
  // what the coming rising edge does to the transfer queues.
  always begin
    @(negedge hclk);
    cyc++;
    if (!hresetn) begin
      hready = 1'b1; hresp = 1'b0; hrdata = '0;
      issue_q.delete();
      dp_act = 1'b0; cancel_pend = 1'b0; exp_rv = 1'b0;
      last_rd = '0; last_re = 1'b0; prev_ok = 1'b0;
    end else begin
      chk_eq("rsp_valid", rsp_valid, exp_rv);
      if (rsp_valid && exp_rv) begin
        chk_eq("rsp_rdata", rsp_rdata, exp_rd);
        chk_eq("rsp_err", rsp_err, exp_re);
        last_rd = exp_rd;
        last_re = exp_re;
      end else if (!rsp_valid) begin
        chk_eq("rsp_rdata_hold", rsp_rdata, last_rd);
        chk_eq("rsp_err_hold", rsp_err, last_re);
      end
      exp_rv = 1'b0;
      chk_eq("hburst", hburst, 32'h0);
      if (prev_ok && !prev_hready) begin
        exp_ht = (prev_hresp && prev_htrans == 2'b10) ? 2'b00 : prev_htrans;
        chk_eq("hold_htrans", htrans, exp_ht);
        chk_eq("hold_haddr", haddr, prev_haddr);
        chk_eq("hold_hwrite", hwrite, prev_hwrite);
        chk_eq("hold_hsize", hsize, prev_hsize);
      end
      if (dp_act) begin
        if (dp_wait > 0) begin
          hready = 1'b0; hresp = 1'b0;
        end else if (dp_err) begin
          hresp = 1'b1; hready = dp_estage;
        end else begin
          hready = 1'b1; hresp = 1'b0;
        end
        if (dp_x.write) chk_eq("hwdata", hwdata, dp_x.wdata);
      end else begin
        hready = 1'b1; hresp = 1'b0;
      end
      hrdata = (dp_act && !dp_x.write && hready && !hresp) ? rdata_of(dp_x.addr)
                                                          : (32'hBAD00000 ^ cyc);
      #1;
      chk_eq("cmd_ready", cmd_ready, hready & ~hresp & ~cancel_pend);
      if (hready) begin
        if (dp_act) begin
          exp_rv = 1'b1;
          exp_re = hresp;
          exp_rd = dp_x.write ? 32'h0 : hrdata;
          dp_act = 1'b0;
        end
        if (htrans == 2'b10) begin
          chk_eq("nonseq_has_cmd", issue_q.size() > 0, 1);
          if (issue_q.size() > 0) begin
            x = issue_q.pop_front();
            chk_eq("ap_haddr", haddr, x.addr);
            chk_eq("ap_hwrite", hwrite, x.write);
            chk_eq("ap_hsize", hsize, x.size);
            dp_act = 1'b1; dp_x = x;
            dp_wait = waits_of(x.addr); dp_err = err_of(x.addr); dp_estage = 1'b0;
            cancel_pend = 1'b0;
          end
        end
      end else begin
        if (dp_act) begin
          if (dp_wait > 0) dp_wait--;
          else if (dp_err) dp_estage = 1'b1;
        end
        if (hresp && htrans == 2'b10) cancel_pend = 1'b1;
      end
      if (cmd_valid && cmd_ready)
        issue_q.push_back({cmd_addr, cmd_write,
                           {1'b0, (cmd_size == 2'b11) ? 2'b10 : cmd_size}, cmd_wdata});
      prev_ok = 1'b1; prev_hready = hready; prev_hresp = hresp;
      prev_htrans = htrans; prev_haddr = haddr; prev_hwrite = hwrite; prev_hsize = hsize;
    end
  end

  task automatic sync();
    @(posedge hclk); #1;
  endtask

  task automatic at_neg(input int n);
    repeat (n) @(negedge hclk);
    #2;
  endtask

  task automatic send(input logic w, input logic [AW-1:0] a, input logic [1:0] s,
                      input logic [31:0] d);
    int  n;
    logic acc;
    cmd_valid = 1'b1; cmd_write = w; cmd_addr = a; cmd_size = s; cmd_wdata = d;
    n = 0; acc = 1'b0;
    while (!acc && n < 50) begin
      @(negedge hclk); #2;
      acc = cmd_ready;
      @(posedge hclk); #1;
      n++;
    end
    if (!acc) chk_eq("cmd_accept_timeout", acc, 1);
  endtask

  task automatic idle();
    cmd_valid = 1'b0;
  endtask

  logic [15:0]   ob_ns, ob_rv, ob_re, ob_cr;
  logic [2:0]    ob_hs [16];
  logic [AW-1:0] ob_ha [16];
  logic [31:0]   ob_rd [16];

  task automatic observe(input int n);
    ob_ns = '0; ob_rv = '0; ob_re = '0; ob_cr = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge hclk); #2;
      ob_ns[i[3:0]] = (htrans == 2'b10);
      ob_rv[i[3:0]] = rsp_valid;
      ob_re[i[3:0]] = rsp_err;
      ob_cr[i[3:0]] = cmd_ready;
      ob_hs[i[3:0]] = hsize;
      ob_ha[i[3:0]] = haddr;
      ob_rd[i[3:0]] = rsp_rdata;
    end
  endtask

  initial begin
    hresetn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0;
    cmd_addr = '0; cmd_size = '0; cmd_wdata = '0;
    at_neg(2);
    chk_eq("rst_htrans", htrans, 0);
    chk_eq("rst_haddr", haddr, 0);
    chk_eq("rst_hwrite", hwrite, 0);
    chk_eq("rst_hsize", hsize, 0);
    chk_eq("rst_hwdata", hwdata, 0);
    chk_eq("rst_rsp_valid", rsp_valid, 0);
    chk_eq("rst_rsp_rdata", rsp_rdata, 0);
    chk_eq("rst_rsp_err", rsp_err, 0);
    chk_eq("rst_cmd_ready", cmd_ready, 1);
    sync();
    hresetn = 1'b1;

    // Single zero-wait write
    sync();
    send(1'b1, 12'h010, 2'd2, 32'hDEADBEEF); idle();
    at_neg(1);
    chk_eq("t1_htrans", htrans, 2'b10);
    chk_eq("t1_haddr", haddr, 12'h010);
    chk_eq("t1_hwrite", hwrite, 1);
    chk_eq("t1_hsize", hsize, 3'b010);
    at_neg(1);
    chk_eq("t1_hwdata", hwdata, 32'hDEADBEEF);
    chk_eq("t1_htrans_idle", htrans, 2'b00);
    at_neg(1);
    chk_eq("t1_rsp_valid", rsp_valid, 1);
    chk_eq("t1_rsp_rdata", rsp_rdata, 0);
    chk_eq("t1_rsp_err", rsp_err, 0);

    // Read with two wait states
    sync();
    send(1'b0, 12'h020, 2'd2, 32'h0); idle();
    at_neg(1);
    chk_eq("t2_htrans", htrans, 2'b10);
    chk_eq("t2_haddr", haddr, 12'h020);
    chk_eq("t2_hwrite", hwrite, 0);
    at_neg(1);
    chk_eq("t2_ready_w1", cmd_ready, 0);
    chk_eq("t2_haddr_w1", haddr, 12'h020);
    at_neg(1);
    chk_eq("t2_ready_w2", cmd_ready, 0);
    at_neg(1);
    chk_eq("t2_ready_end", cmd_ready, 1);
    chk_eq("t2_no_rsp_yet", rsp_valid, 0);
    at_neg(1);
    chk_eq("t2_rsp_valid", rsp_valid, 1);
    chk_eq("t2_rsp_rdata", rsp_rdata, 32'h12345678);

    // Back-to-back writes
    sync();
    fork
      begin
        send(1'b1, 12'h000, 2'd2, 32'h11110000);
        send(1'b1, 12'h004, 2'd2, 32'h22220004);
        send(1'b1, 12'h008, 2'd2, 32'h33330008);
        send(1'b1, 12'h00C, 2'd2, 32'h4444000C);
        idle();
      end
      observe(10);
    join
    chk_eq("t3_nonseq_pattern", ob_ns, 16'h001E);
    chk_eq("t3_rsp_pattern", ob_rv, 16'h0078);

    // Size mapping
    sync();
    fork
      begin
        send(1'b0, 12'h003, 2'd0, 32'h0);
        send(1'b0, 12'h002, 2'd1, 32'h0);
        send(1'b0, 12'h000, 2'd3, 32'h0);
        idle();
      end
      observe(7);
    join
    chk_eq("t4_hsize_b", ob_hs[1], 3'b000);
    chk_eq("t4_hsize_h", ob_hs[2], 3'b001);
    chk_eq("t4_hsize_w", ob_hs[3], 3'b010);
    chk_eq("t4_haddr_b", ob_ha[1], 12'h003);
    chk_eq("t4_haddr_h", ob_ha[2], 12'h002);
    chk_eq("t4_haddr_w", ob_ha[3], 12'h000);

    // ERROR on a write with a pipelined read behind it
    sync();
    fork
      begin
        send(1'b1, 12'h100, 2'd2, 32'hCAFE0100);
        send(1'b0, 12'h104, 2'd2, 32'h0);
        idle();
      end
      observe(8);
    join
    chk_eq("t5_nonseq_pattern", ob_ns, 16'h0016);
    chk_eq("t5_rsp_pattern", ob_rv, 16'h0050);
    chk_eq("t5_err_first", ob_re[4], 1);
    chk_eq("t5_ready_err2", ob_cr[3], 0);
    chk_eq("t5_ready_replay", ob_cr[4], 0);
    chk_eq("t5_replay_addr", ob_ha[4], 12'h104);
    chk_eq("t5_read_rdata", ob_rd[6], 32'hC0FFE104);
    chk_eq("t5_read_ok", ob_re[6], 0);

    // Reset during a wait-stated read
    sync();
    send(1'b0, 12'h040, 2'd2, 32'h0BAD0BAD); idle();
    at_neg(2);
    #1;
    hresetn = 1'b0;
    #1;
    chk_eq("t6_htrans", htrans, 0);
    chk_eq("t6_haddr", haddr, 0);
    chk_eq("t6_hwrite", hwrite, 0);
    chk_eq("t6_hsize", hsize, 0);
    chk_eq("t6_hwdata", hwdata, 0);
    chk_eq("t6_rsp_valid", rsp_valid, 0);
    chk_eq("t6_rsp_rdata", rsp_rdata, 0);
    chk_eq("t6_rsp_err", rsp_err, 0);
    repeat (2) @(posedge hclk);
    #1;
    hresetn = 1'b1;
    repeat (4) sync();
    send(1'b1, 12'h080, 2'd2, 32'h5A5A0080); idle();
    at_neg(1);
    chk_eq("t6_new_htrans", htrans, 2'b10);
    chk_eq("t6_new_haddr", haddr, 12'h080);
    at_neg(2);
    chk_eq("t6_new_rsp_valid", rsp_valid, 1);
    chk_eq("t6_new_rsp_err", rsp_err, 0);

    repeat (3) sync();
    chk_eq("drained", issue_q.size() + int'(dp_act), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
